// File: rtl/irrigation_cycle_scheduler.sv
// Sequences one drip/sprinkler watering cycle from soil/tank sensors, timed by a prescaled down-counter.
// Latency: all outputs registered; valve opens 1 clk after the START load pulse and closes on the edge leaving WATER.
// Backpressure: none; sensor inputs are sampled every clk and the downstream load pulse cannot be stalled.
module irrigation_cycle_scheduler #(
    parameter int TICK_DIV       = 50,
    parameter int DRIP_TIME      = 10,
    parameter int SPRINKLER_TIME = 6,
    parameter int COOLDOWN_TIME  = 3,
    parameter int CNT_W          = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             soil_dry,
    input  logic             soil_wet,
    input  logic             tank_low,
    input  logic             mode,
    output logic             valve_drip,
    output logic             valve_sprinkler,
    output logic             counter_load,
    output logic [CNT_W-1:0] remaining,
    output logic             busy,
    output logic             alarm,
    output logic [2:0]       state
);

    localparam int PW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int CMAX = (1 << CNT_W) - 1;

    localparam logic [CNT_W-1:0] DRIP_LD = CNT_W'(DRIP_TIME);
    localparam logic [CNT_W-1:0] SPR_LD  = CNT_W'(SPRINKLER_TIME);
    localparam logic [CNT_W-1:0] CD_LD   = CNT_W'(COOLDOWN_TIME);
    localparam logic [PW-1:0]    TICK_AT = PW'(TICK_DIV - 1);

    if (TICK_DIV < 2) begin : g_bad_tick_div
        $error("TICK_DIV must be at least 2");
    end
    if (DRIP_TIME < 1 || DRIP_TIME > CMAX) begin : g_bad_drip_time
        $error("DRIP_TIME out of range for CNT_W");
    end
    if (SPRINKLER_TIME < 1 || SPRINKLER_TIME > CMAX) begin : g_bad_sprinkler_time
        $error("SPRINKLER_TIME out of range for CNT_W");
    end
    if (COOLDOWN_TIME < 1 || COOLDOWN_TIME > CMAX) begin : g_bad_cooldown_time
        $error("COOLDOWN_TIME out of range for CNT_W");
    end

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        WATER    = 3'd2,
        COOLDOWN = 3'd3,
        FAULT    = 3'd4
    } state_t;

    state_t           state_q, state_nxt;
    logic [PW-1:0]    presc_q, presc_nxt;
    logic [CNT_W-1:0] remaining_q, remaining_nxt;
    logic             mode_q, mode_nxt;
    logic             tick;

    assign tick = (presc_q == TICK_AT);

    always_comb begin
        state_nxt     = state_q;
        remaining_nxt = remaining_q;
        mode_nxt      = mode_q;
        unique case (state_q)
            IDLE: begin
                if (enable && soil_dry && !soil_wet && !tank_low) begin
                    state_nxt     = START;
                    mode_nxt      = mode;
                    remaining_nxt = mode ? SPR_LD : DRIP_LD;
                end else if (enable && soil_dry && tank_low) begin
                    state_nxt     = FAULT;
                    remaining_nxt = '0;
                end
            end
            START: state_nxt = WATER;
            WATER: begin
                // Fault beats operator stop, which beats early-wet stop, which beats timeout.
                if (tank_low) begin
                    state_nxt     = FAULT;
                    remaining_nxt = '0;
                end else if (!enable || soil_wet || (tick && remaining_q == CNT_W'(1))) begin
                    state_nxt     = COOLDOWN;
                    remaining_nxt = CD_LD;
                end else if (tick) begin
                    remaining_nxt = remaining_q - CNT_W'(1);
                end
            end
            COOLDOWN: begin
                if (tank_low) begin
                    state_nxt     = FAULT;
                    remaining_nxt = '0;
                end else if (tick) begin
                    remaining_nxt = remaining_q - CNT_W'(1);
                    if (remaining_q == CNT_W'(1)) state_nxt = IDLE;
                end
            end
            FAULT: begin
                remaining_nxt = '0;
                if (!tank_low && !enable) state_nxt = IDLE;
            end
            default: begin
                state_nxt     = IDLE;
                remaining_nxt = '0;
            end
        endcase
    end

    // Prescaler restarts on every state change so each phase gets whole ticks.
    always_comb begin
        presc_nxt = '0;
        if (state_nxt == state_q && !tick && (state_q == WATER || state_q == COOLDOWN))
            presc_nxt = presc_q + PW'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            presc_q         <= '0;
            remaining_q     <= '0;
            mode_q          <= 1'b0;
            valve_drip      <= 1'b0;
            valve_sprinkler <= 1'b0;
            counter_load    <= 1'b0;
            alarm           <= 1'b0;
        end else begin
            state_q         <= state_nxt;
            presc_q         <= presc_nxt;
            remaining_q     <= remaining_nxt;
            mode_q          <= mode_nxt;
            valve_drip      <= (state_nxt == WATER) && !mode_nxt;
            valve_sprinkler <= (state_nxt == WATER) && mode_nxt;
            counter_load    <= (state_nxt == START);
            alarm           <= (state_nxt == FAULT);
        end
    end

    assign remaining = remaining_q;
    assign busy      = (state_q == WATER) || (state_q == COOLDOWN);
    assign state     = state_q;

endmodule

// File: tb/tb_irrigation_cycle_scheduler.sv
// Directed bench for irrigation_cycle_scheduler: elapsed-clock reference model checked every cycle,
// plus hand-computed phase lengths and fault/reset scenarios.
module tb_irrigation_cycle_scheduler;

    localparam int TD    = 4;
    localparam int DRIP  = 10;
    localparam int SPR   = 6;
    localparam int CD    = 3;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             enable = 1'b0;
    logic             soil_dry = 1'b0;
    logic             soil_wet = 1'b0;
    logic             tank_low = 1'b0;
    logic             mode = 1'b0;
    logic             valve_drip;
    logic             valve_sprinkler;
    logic             counter_load;
    logic [CNT_W-1:0] remaining;
    logic             busy;
    logic             alarm;
    logic [2:0]       state;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    irrigation_cycle_scheduler #(
        .TICK_DIV(TD), .DRIP_TIME(DRIP), .SPRINKLER_TIME(SPR),
        .COOLDOWN_TIME(CD), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .soil_dry(soil_dry),
        .soil_wet(soil_wet), .tank_low(tank_low), .mode(mode),
        .valve_drip(valve_drip), .valve_sprinkler(valve_sprinkler),
        .counter_load(counter_load), .remaining(remaining), .busy(busy),
        .alarm(alarm), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: phase + clocks elapsed in phase; remaining = length - elapsed/TD.
    int   m_st = 0;
    int   m_el = 0;
    int   m_len = 0;
    logic m_mode = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_st <= 0; m_el <= 0; m_len <= 0; m_mode <= 1'b0;
        end else begin
            case (m_st)
                0: if (enable && soil_dry && !soil_wet && !tank_low) begin
                       m_st <= 1; m_mode <= mode; m_len <= mode ? SPR : DRIP;
                   end else if (enable && soil_dry && tank_low) m_st <= 4;
                1: begin m_st <= 2; m_el <= 0; end
                2: if (tank_low) m_st <= 4;
                   else if (!enable || soil_wet || (m_el + 1 == m_len * TD)) begin
                       m_st <= 3; m_len <= CD; m_el <= 0;
                   end else m_el <= m_el + 1;
                3: if (tank_low) m_st <= 4;
                   else if (m_el + 1 == m_len * TD) m_st <= 0;
                   else m_el <= m_el + 1;
                4: if (!tank_low && !enable) m_st <= 0;
                default: m_st <= 0;
            endcase
        end
    end

    function automatic int exp_rem();
        if (m_st == 1) return m_len;
        if (m_st == 2 || m_st == 3) return m_len - m_el / TD;
        return 0;
    endfunction

    int drip_cnt = 0;
    int spr_cnt = 0;
    int load_cnt = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("state", int'(state), m_st);
            chk("valve_drip", int'(valve_drip), int'(m_st == 2 && !m_mode));
            chk("valve_sprinkler", int'(valve_sprinkler), int'(m_st == 2 && m_mode));
            chk("counter_load", int'(counter_load), int'(m_st == 1));
            chk("remaining", int'(remaining), exp_rem());
            chk("busy", int'(busy), int'(m_st == 2 || m_st == 3));
            chk("alarm", int'(alarm), int'(m_st == 4));
        end
        if (valve_drip) drip_cnt <= drip_cnt + 1;
        if (valve_sprinkler) spr_cnt <= spr_cnt + 1;
        if (counter_load) load_cnt <= load_cnt + 1;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_state"}, int'(state), 0);
        chk({nm, "_drip"}, int'(valve_drip), 0);
        chk({nm, "_spr"}, int'(valve_sprinkler), 0);
        chk({nm, "_load"}, int'(counter_load), 0);
        chk({nm, "_rem"}, int'(remaining), 0);
        chk({nm, "_busy"}, int'(busy), 0);
        chk({nm, "_alarm"}, int'(alarm), 0);
    endtask

    initial begin
        int n;
        int l0;
        int d0;
        int s0;

        cyc(3);
        chk_all_zero("reset");
        reset = 1'b1;
        chk_en = 1'b1;
        cyc(2);

        // 1: drip cycle runs to completion
        mode = 1'b0; enable = 1'b1; soil_dry = 1'b1;
        l0 = load_cnt; s0 = spr_cnt;
        cyc(1);
        chk("t1_start_state", int'(state), 1);
        chk("t1_load", int'(counter_load), 1);
        chk("t1_rem_loaded", int'(remaining), DRIP);
        soil_dry = 1'b0;
        cyc(1);
        chk("t1_load_width", int'(counter_load), 0);
        n = 0;
        while (valve_drip && n < 100) begin n++; cyc(1); end
        chk("t1_drip_clks", n, DRIP * TD);
        chk("t1_cool_rem", int'(remaining), CD);
        n = 0;
        while (busy && n < 100) begin n++; cyc(1); end
        chk("t1_cool_clks", n, CD * TD);
        chk("t1_idle", int'(state), 0);
        chk("t1_load_pulses", load_cnt - l0, 1);
        chk("t1_no_sprinkler", spr_cnt - s0, 0);

        // 2: sprinkler, mode toggled mid-WATER is ignored
        mode = 1'b1; soil_dry = 1'b1;
        d0 = drip_cnt;
        cyc(1);
        chk("t2_start_state", int'(state), 1);
        soil_dry = 1'b0;
        cyc(1);
        n = 0;
        while (valve_sprinkler && n < 100) begin
            n++;
            if (n == 8) mode = 1'b0;
            cyc(1);
        end
        chk("t2_spr_clks", n, SPR * TD);
        n = 0;
        while (busy && n < 100) begin n++; cyc(1); end
        chk("t2_cool_clks", n, CD * TD);
        chk("t2_no_drip", drip_cnt - d0, 0);

        // 3: soil_wet after three ticks stops early
        mode = 1'b0; soil_dry = 1'b1;
        cyc(1);
        soil_dry = 1'b0;
        cyc(1);
        cyc(3 * TD);
        chk("t3_rem_before_wet", int'(remaining), DRIP - 3);
        soil_wet = 1'b1;
        cyc(1);
        chk("t3_valve_closed", int'(valve_drip), 0);
        chk("t3_state_cool", int'(state), 3);
        chk("t3_rem_cool", int'(remaining), CD);
        n = 0;
        while (busy && n < 100) begin n++; cyc(1); end
        chk("t3_cool_clks", n, CD * TD);
        soil_wet = 1'b0;
        chk("t3_idle", int'(state), 0);

        // 4: tank_low beats soil_wet; fault needs enable low to clear
        soil_dry = 1'b1;
        cyc(1);
        soil_dry = 1'b0;
        cyc(7);
        tank_low = 1'b1; soil_wet = 1'b1;
        cyc(1);
        chk("t4_fault", int'(state), 4);
        chk("t4_alarm", int'(alarm), 1);
        chk("t4_valve", int'(valve_drip), 0);
        chk("t4_rem", int'(remaining), 0);
        tank_low = 1'b0; soil_wet = 1'b0;
        cyc(3);
        chk("t4_stays_fault", int'(state), 4);
        enable = 1'b0;
        cyc(1);
        chk("t4_ack_idle", int'(state), 0);
        chk("t4_alarm_clr", int'(alarm), 0);
        enable = 1'b1;

        // 5: asynchronous reset mid-WATER
        soil_dry = 1'b1;
        cyc(1);
        soil_dry = 1'b0;
        cyc(1);
        cyc(5 * TD);
        chk("t5_rem5", int'(remaining), 5);
        chk("t5_valve_on", int'(valve_drip), 1);
        #1 reset = 1'b0;
        #1;
        chk("t5_async_valve", int'(valve_drip), 0);
        chk("t5_async_state", int'(state), 0);
        enable = 1'b0;
        cyc(2);
        reset = 1'b1;
        cyc(1);
        chk_all_zero("t5_after");
        enable = 1'b1;

        // 6: dry and wet together never starts
        soil_dry = 1'b1; soil_wet = 1'b1;
        l0 = load_cnt;
        cyc(10);
        chk("t6_state", int'(state), 0);
        chk("t6_no_load", load_cnt - l0, 0);
        soil_dry = 1'b0; soil_wet = 1'b0;
        cyc(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/irrigation_cycle_scheduler.md
Name: irrigation_cycle_scheduler

Overview:
Sequences one irrigation cycle for the drip/sprinkler section. It decides when to open a valve from soil-moisture and tank-level inputs, and times the watering interval with an internal down-counter driven by a prescaled tick. It emits a one-cycle load pulse that restarts the downstream drip ten-counter/display counters, and exports the remaining time for display. It sits between the sensor-conditioning logic and the valve drivers/counter display.

Parameters:
TICK_DIV, 50, clk cycles per time tick (≥2)
DRIP_TIME, 10, ticks a drip cycle lasts (1..2^CNT_W-1)
SPRINKLER_TIME, 6, ticks a sprinkler cycle lasts (1..2^CNT_W-1)
COOLDOWN_TIME, 3, ticks of forced rest after any cycle (≥1)
CNT_W, 4, width of the remaining-time counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous reset, active-low
enable  in  1  global run enable; low aborts/blocks cycles
soil_dry  in  1  moisture below low threshold
soil_wet  in  1  moisture above high threshold (wins over soil_dry if both high)
tank_low  in  1  water tank below minimum
mode  in  1  0 = drip, 1 = sprinkler; sampled at cycle start only
valve_drip  out  1  drip valve open
valve_sprinkler  out  1  sprinkler valve open
counter_load  out  1  one-cycle pulse restarting downstream counters
remaining  out  CNT_W  ticks left in current watering/cooldown phase
busy  out  1  high in WATER or COOLDOWN
alarm  out  1  tank-low fault latched
state  out  3  IDLE=0, START=1, WATER=2, COOLDOWN=3, FAULT=4

Behaviour:
- Reset (reset=0, async): state=IDLE, all outputs 0, remaining=0, prescaler=0, latched mode=0.
- Prescaler counts 0..TICK_DIV-1 only in WATER/COOLDOWN; tick = 1 clk when it equals TICK_DIV-1. Cleared on every state entry.
- IDLE: if enable & soil_dry & !soil_wet & !tank_low -> START. If enable & soil_dry & tank_low -> FAULT. Otherwise stay.
- START (exactly 1 clk): latch mode; counter_load=1; remaining loaded with DRIP_TIME or SPRINKLER_TIME per mode -> WATER.
- WATER: valve selected by latched mode is high, the other is low; never both high. On tick, remaining decrements. Exit to COOLDOWN (remaining=COOLDOWN_TIME, valves closed the same edge) when the tick makes remaining 0, OR soil_wet=1 (early stop), OR enable=0. tank_low=1 -> FAULT, valves closed immediately. Priority: tank_low > enable=0 > soil_wet > timeout.
- COOLDOWN: valves closed; remaining decrements on tick; at 0 -> IDLE. enable has no effect (rest always completes); tank_low here sets alarm and goes to FAULT.
- FAULT: alarm=1, valves closed, remaining=0. Leaves to IDLE only when tank_low=0 and enable=0 have been seen in the same clk (operator acknowledge). alarm clears on that exit.
- Watering length is N×TICK_DIV clk ±1 clk; the mode change during WATER is ignored.
- Valve outputs are registered: a valve rises 1 clk after START and falls on the same edge that leaves WATER.
- remaining never wraps: a decrement at 0 is impossible by construction; an out-of-range parameter is an elaboration error.
- Reset mid-cycle closes valves asynchronously.

Test Plan:
- TICK_DIV=4, DRIP_TIME=10, mode=0, soil_dry=1 -> counter_load pulse 1 clk, valve_drip high for 40 clk, then COOLDOWN 12 clk, then IDLE; valve_sprinkler stays 0.
- mode=1 at start, then mode toggled to 0 mid-WATER -> valve_sprinkler stays high for SPRINKLER_TIME=6 ticks (24 clk); valve_drip never rises.
- soil_wet asserted at tick 3 of WATER -> valves close on that edge, remaining=3 (COOLDOWN_TIME), IDLE after 12 clk.
- tank_low asserted in WATER with soil_wet also high -> FAULT (tank priority), alarm=1; clear tank_low with enable=1 -> stays FAULT; then enable=0 -> IDLE, alarm=0.
- reset pulled low mid-WATER at remaining=5 -> valve_drip drops without a clk edge; all outputs 0 and state=0 after release.
- soil_dry=soil_wet=1 in IDLE with enable=1 -> no START; state stays 0 and counter_load never pulses.
